// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision multiplier.
//   Field widths, exponent bias, canonical quiet NaN, operand class,
//   FSM state encoding and the unpacked-operand struct.
package fp_pkg;

    localparam int unsigned FP_WIDTH   = 32;
    localparam int unsigned EXP_WIDTH  = 8;
    localparam int unsigned MAN_WIDTH  = 23;
    localparam int unsigned SIG_WIDTH  = MAN_WIDTH + 1;   // hidden bit included
    localparam int unsigned RND_WIDTH  = SIG_WIDTH + 1;   // room for rounding carry
    localparam int unsigned PROD_WIDTH = 2 * SIG_WIDTH;
    localparam int unsigned EXPI_WIDTH = 10;              // signed exponent intermediate
    localparam int unsigned BIAS       = 127;

    localparam logic [FP_WIDTH-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_NORM,
        S_PACK
    } state_e;

    typedef struct packed {
        logic                 sign;
        logic [EXP_WIDTH-1:0] exp;
        logic [SIG_WIDTH-1:0] man;
        fp_class_e            cls;
    } fp_unpacked_t;

endpackage

// File: rtl/fp_classify.sv
// Splits one binary32 operand into sign/exponent/significand and classifies it.
//   op  : raw IEEE-754 binary32 operand
//   unp : unpacked fields; denormals report FP_ZERO (flush-to-zero)
module fp_classify
    import fp_pkg::*;
(
    input  logic [FP_WIDTH-1:0] op,
    output fp_unpacked_t        unp
);

    logic [EXP_WIDTH-1:0] exp_c;
    logic [MAN_WIDTH-1:0] frac_c;

    assign exp_c  = op[FP_WIDTH-2 -: EXP_WIDTH];
    assign frac_c = op[MAN_WIDTH-1:0];

    // Hidden bit inserted for normals; zero and denormal both collapse to zero.
    always_comb begin
        unp.sign = op[FP_WIDTH-1];
        unp.exp  = exp_c;
        unp.man  = {1'b1, frac_c};
        unp.cls  = FP_NORM;
        if (exp_c == '0) begin
            unp.cls = FP_ZERO;
            unp.man = '0;
        end else if (&exp_c) begin
            unp.cls = (frac_c != '0) ? FP_NAN : FP_INF;
        end
    end

endmodule

// File: rtl/fp_mult_unit.sv
// Multi-cycle binary32 multiplier, start/clk_en/done responder.
//   clk, rst_n     : clock, asynchronous active-low reset
//   clk_en         : global stall, freezes every register when low
//   start          : request, dataa/datab sampled on the accepting edge
//   result         : registered product, valid from the done cycle onward
//   done           : one-enabled-cycle pulse, 4 enabled edges after accept
//   busy           : high from accept through the done cycle
module fp_mult_unit
    import fp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic                start,
    input  logic [FP_WIDTH-1:0] dataa,
    input  logic [FP_WIDTH-1:0] datab,
    output logic [FP_WIDTH-1:0] result,
    output logic                done,
    output logic                busy
);

    localparam int unsigned G_BIT = PROD_WIDTH - SIG_WIDTH - 1;   // guard when bit 47 set

    state_e                        state_q, state_d;
    logic [FP_WIDTH-1:0]           op_a_q, op_a_d, op_b_q, op_b_d;
    logic [SIG_WIDTH-1:0]          ma_q, ma_d, mb_q, mb_d;
    logic [EXP_WIDTH-1:0]          ea_q, ea_d, eb_q, eb_d;
    logic                          sign_q, sign_d;
    logic                          spec_q, spec_d;
    logic [FP_WIDTH-1:0]           spec_res_q, spec_res_d;
    logic [PROD_WIDTH-1:0]         prod_q, prod_d;
    logic signed [EXPI_WIDTH-1:0]  exp_q, exp_d;
    logic [SIG_WIDTH-1:0]          sig_q, sig_d;
    logic                          guard_q, guard_d, rnd_q, rnd_d, sticky_q, sticky_d;
    logic [FP_WIDTH-1:0]           result_q, result_d;
    logic                          done_q, done_d, busy_q, busy_d;

    fp_unpacked_t                  ua_c, ub_c;
    logic                          round_up_c;
    logic [RND_WIDTH-1:0]          sig_rnd_c;
    logic signed [EXPI_WIDTH-1:0]  exp_rnd_c;
    logic [MAN_WIDTH-1:0]          man_rnd_c;

    fp_classify u_cls_a (.op(op_a_q), .unp(ua_c));
    fp_classify u_cls_b (.op(op_b_q), .unp(ub_c));

    // Round-to-nearest-even on the normalised significand.
    always_comb begin
        round_up_c = guard_q & (rnd_q | sticky_q | sig_q[0]);
        sig_rnd_c  = {1'b0, sig_q} + RND_WIDTH'(round_up_c);
        exp_rnd_c  = sig_rnd_c[SIG_WIDTH] ? exp_q + 10'sd1 : exp_q;
        man_rnd_c  = sig_rnd_c[SIG_WIDTH] ? sig_rnd_c[MAN_WIDTH:1] : sig_rnd_c[MAN_WIDTH-1:0];
    end

    // Next-state and datapath stage logic.
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        ea_d       = ea_q;
        eb_d       = eb_q;
        sign_d     = sign_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        prod_d     = prod_q;
        exp_d      = exp_q;
        sig_d      = sig_q;
        guard_d    = guard_q;
        rnd_d      = rnd_q;
        sticky_d   = sticky_q;
        result_d   = result_q;
        done_d     = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            S_IDLE: begin
                // busy covers the done cycle, then drops unless a new op starts
                if (done_q) busy_d = 1'b0;
                if (start) begin
                    state_d = S_UNPACK;
                    op_a_d  = dataa;
                    op_b_d  = datab;
                    busy_d  = 1'b1;
                end
            end
            S_UNPACK: begin
                ma_d   = ua_c.man;
                mb_d   = ub_c.man;
                ea_d   = ua_c.exp;
                eb_d   = ub_c.exp;
                sign_d = ua_c.sign ^ ub_c.sign;
                spec_d = 1'b1;
                if (ua_c.cls == FP_NAN || ub_c.cls == FP_NAN ||
                    (ua_c.cls == FP_INF  && ub_c.cls == FP_ZERO) ||
                    (ua_c.cls == FP_ZERO && ub_c.cls == FP_INF)) begin
                    spec_res_d = QNAN;
                end else if (ua_c.cls == FP_INF || ub_c.cls == FP_INF) begin
                    spec_res_d = {ua_c.sign ^ ub_c.sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
                end else if (ua_c.cls == FP_ZERO || ub_c.cls == FP_ZERO) begin
                    spec_res_d = {ua_c.sign ^ ub_c.sign, {(FP_WIDTH-1){1'b0}}};
                end else begin
                    spec_d     = 1'b0;
                    spec_res_d = '0;
                end
                state_d = S_MULT;
            end
            S_MULT: begin
                prod_d  = PROD_WIDTH'(ma_q) * PROD_WIDTH'(mb_q);
                exp_d   = $signed(EXPI_WIDTH'(ea_q)) + $signed(EXPI_WIDTH'(eb_q))
                        - $signed(EXPI_WIDTH'(BIAS));
                state_d = S_NORM;
            end
            S_NORM: begin
                // product lies in [1,4); a set top bit means one extra binade
                if (prod_q[PROD_WIDTH-1]) begin
                    sig_d    = prod_q[PROD_WIDTH-1 -: SIG_WIDTH];
                    guard_d  = prod_q[G_BIT];
                    rnd_d    = prod_q[G_BIT-1];
                    sticky_d = |prod_q[G_BIT-2:0];
                    exp_d    = exp_q + 10'sd1;
                end else begin
                    sig_d    = prod_q[PROD_WIDTH-2 -: SIG_WIDTH];
                    guard_d  = prod_q[G_BIT-1];
                    rnd_d    = prod_q[G_BIT-2];
                    sticky_d = |prod_q[G_BIT-3:0];
                end
                state_d = S_PACK;
            end
            S_PACK: begin
                if (spec_q) begin
                    result_d = spec_res_q;
                end else if (exp_rnd_c >= 10'sd255) begin
                    result_d = {sign_q, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
                end else if (exp_rnd_c <= 10'sd0) begin
                    result_d = {sign_q, {(FP_WIDTH-1){1'b0}}};
                end else begin
                    result_d = {sign_q, exp_rnd_c[EXP_WIDTH-1:0], man_rnd_c};
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; clk_en low holds everything, including a pending done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            ma_q       <= '0;
            mb_q       <= '0;
            ea_q       <= '0;
            eb_q       <= '0;
            sign_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            prod_q     <= '0;
            exp_q      <= '0;
            sig_q      <= '0;
            guard_q    <= 1'b0;
            rnd_q      <= 1'b0;
            sticky_q   <= 1'b0;
            result_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            ea_q       <= ea_d;
            eb_q       <= eb_d;
            sign_q     <= sign_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            prod_q     <= prod_d;
            exp_q      <= exp_d;
            sig_q      <= sig_d;
            guard_q    <= guard_d;
            rnd_q      <= rnd_d;
            sticky_q   <= sticky_d;
            result_q   <= result_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_fp_mult_unit.sv
// Self-checking bench for fp_mult_unit: directed cases, handshake/stall/reset
// scenarios and randomized operands against an integer-arithmetic reference.
module tb_fp_mult_unit;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        clk_en = 1'b0;
    logic        start  = 1'b0;
    logic [31:0] dataa  = '0;
    logic [31:0] datab  = '0;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int tests = 0;
    int fails = 0;

    fp_mult_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product, generic MSB search, remainder-based RNE.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic             s;
        int               ea, eb, e, n, sh;
        longint unsigned  fa, fb, p, q, rem, half;
        logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = 64'(a[22:0]);
        fb = 64'(b[22:0]);
        a_nan  = (ea == 255) && (fa != 0);
        b_nan  = (eb == 255) && (fb != 0);
        a_inf  = (ea == 255) && (fa == 0);
        b_inf  = (eb == 255) && (fb == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) return 32'h7FC00000;
        if (a_inf || b_inf) return {s, 8'hFF, 23'h0};
        if (a_zero || b_zero) return {s, 31'h0};
        p = (fa + (64'd1 << 23)) * (fb + (64'd1 << 23));
        n = 63;
        while (n > 0 && p[n] == 1'b0) n--;
        sh   = n - 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            n++;
        end
        e = ea + eb - 127 + (n - 46);
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int          k;
        logic [7:0]  e;
        logic [22:0] f;
        k = int'($urandom_range(0, 15));
        f = 23'($urandom);
        if ($urandom_range(0, 2) == 0) f = f & ~(23'($urandom) | 23'($urandom));
        case (k)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 254));
            default: e = 8'($urandom_range(96, 158));
        endcase
        return {1'($urandom), e, f};
    endfunction

    // Drive a one-cycle start; returns just after the accepting edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        dataa = a;
        datab = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts enabled edges after acceptance until done, bounded.
    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int lat;
        launch(a, b);
        wait_done(0, lat);
        check({tag, " latency"}, 32'(lat), 32'd4);
        check(tag, result, exp);
    endtask

    initial begin
        int lat, nb, pulses;
        logic [31:0] a, b, res;

        // reset state
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset result", result, 32'h0);
        check("reset done", 32'(done), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 3.0*3.0 with busy window and latency
        launch(32'h40400000, 32'h40400000);
        nb  = 0;
        lat = -1;
        res = '0;
        for (int i = 0; i < 7; i++) begin
            if (busy === 1'b1) nb++;
            if (done === 1'b1) begin
                lat = i;
                res = result;
            end
            @(negedge clk);
        end
        check("3x3 busy cycles", 32'(nb), 32'd5);
        check("3x3 done latency", 32'(lat), 32'd4);
        check("3x3 result", res, 32'h41100000);

        // directed arithmetic and specials, issued back-to-back
        run_op("1.5x-2", 32'h3FC00000, 32'hC0000000, 32'hC0400000);
        run_op("rne", 32'h3F800001, 32'h3F800001, 32'h3F800002);
        run_op("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000);
        run_op("inf x zero", 32'h7F800000, 32'h00000000, 32'h7FC00000);
        run_op("ftz", 32'h00000001, 32'h3F800000, 32'h00000000);
        run_op("underflow", 32'h00800000, 32'h00800000, 32'h00000000);
        run_op("-inf x 2", 32'hFF800000, 32'h40000000, 32'hFF800000);
        run_op("nan x 1", 32'h7F800001, 32'h3F800000, 32'h7FC00000);
        run_op("-0 x 3", 32'h80000000, 32'h40400000, 32'h80000000);

        // randomized operands against the reference
        for (int i = 0; i < 60; i++) begin
            a = rand_op();
            b = rand_op();
            run_op($sformatf("rand%0d %h*%h", i, a, b), a, b, ref_mul(a, b));
        end
        @(negedge clk);

        // second start while busy is ignored
        launch(32'h3FC00000, 32'h3FC00000);
        @(negedge clk);
        dataa = 32'h40400000;
        datab = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        lat    = -1;
        res    = '0;
        for (int i = 2; i <= 12; i++) begin
            if (done === 1'b1) begin
                pulses++;
                lat = i;
                res = result;
            end
            @(negedge clk);
        end
        check("ignored start pulses", 32'(pulses), 32'd1);
        check("ignored start latency", 32'(lat), 32'd4);
        check("ignored start result", res, ref_mul(32'h3FC00000, 32'h3FC00000));

        // stall of 3 cycles while in MULT
        a = 32'h40A00000;
        b = 32'hC0E00000;
        launch(a, b);
        @(negedge clk);
        clk_en = 1'b0;
        repeat (3) @(negedge clk);
        check("stall busy held", 32'(busy), 32'd1);
        check("stall done low", 32'(done), 32'd0);
        clk_en = 1'b1;
        wait_done(4, lat);
        check("stall latency", 32'(lat), 32'd7);
        check("stall result", result, ref_mul(a, b));

        // stall in the done cycle keeps done high
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("done held %0d", i), 32'(done), 32'd1);
        end
        clk_en = 1'b1;
        @(negedge clk);
        check("done released", 32'(done), 32'd0);
        check("busy released", 32'(busy), 32'd0);

        // asynchronous reset while in NORM
        launch(32'h40400000, 32'h40400000);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst result", result, 32'h0);
        check("async rst done", 32'(done), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("no done after reset", 32'(pulses), 32'd0);
        run_op("2x2 after reset", 32'h40000000, 32'h40000000, 32'h40800000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
